fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Program counter and instruction-fetch front end of the 5-stage MIPS pipeline; consumes rsrtequ from the ID-stage equality checker.
//  Resolves beq/bne/j/jr in ID with one delay slot, selects next PC and runs a req/ready handshake to instruction memory.
//  Owns the IF/ID register contents (if_inst, if_pc4, if_valid), the stall skid buffer and a fetch-wait counter.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch address after reset
//  CNT_W     32             width of stall_cnt
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      reset, synchronous, active-high
//  wpcir       in   1      1 = advance IF/ID and PC; 0 = hazard stall (hold)
//  id_beq      in   1      ID instruction is beq (decoded from if_inst)
//  id_bne      in   1      ID instruction is bne
//  id_j        in   1      ID instruction is j or jal
//  id_jr       in   1      ID instruction is jr
//  rsrtequ     in   1      equality of forwarded rs/rt operands in ID
//  bpc         in   32     branch target (if_pc4 + sext(imm)<<2)
//  jpc         in   32     jump target {if_pc4[31:28], addr26, 2'b00}
//  ra          in   32     jr target (forwarded rs operand qa)
//  imem_req    out  1      fetch request
//  imem_addr   out  32     fetch address (= pc)
//  imem_ready  in   1      fetch data valid this cycle; meaningful only while imem_req
//  imem_rdata  in   32     instruction word
//  if_inst     out  32     IF/ID instruction
//  if_pc4      out  32     IF/ID fetch address + 4
//  if_valid    out  1      IF/ID holds a real instruction (0 = bubble)
//  pc          out  32     current fetch address
//  stall_cnt   out  CNT_W  cycles with imem_req & ~imem_ready
// BEHAVIOUR
//  - Reset (rst wins over all inputs): pc=RESET_PC, state=S_REQ, if_inst=0, if_pc4=0, if_valid=0, buffer empty, stall_cnt=0, imem_req=0 in reset cycle.
//  - Outstanding request abandoned on rst; imem tolerates req drop. Next request issues the first cycle after rst deasserts.
//  - Handshake: imem_req=1 in S_REQ, imem_addr=pc held stable until imem_ready; transfer completes in a cycle with req&ready.
//  - Decision (combinational, ID instr gated by if_valid): taken = (id_beq&rsrtequ)|(id_bne&~rsrtequ).
//  - Priority jr > j > taken branch > pc+4. npc = ra / jpc / bpc / pc+4; npc[1:0] forced to 2'b00.
//  - PC updates only when a fetched word moves into IF/ID (delay slot: the word fetched while a branch sits in ID is executed).
//  - S_REQ, ready & wpcir: if_inst<=imem_rdata, if_pc4<=pc+4, if_valid<=1, pc<=npc, stay S_REQ; next request at npc next cycle.
//  - S_REQ, ready & ~wpcir: buf<=imem_rdata, IF/ID held, pc held, go S_HOLD.
//  - S_REQ, ~ready & wpcir: if_valid<=0 (bubble), pc held. S_REQ, ~ready & ~wpcir: everything held.
//  - S_HOLD: imem_req=0. On wpcir: if_inst<=buf, if_pc4<=pc+4, if_valid<=1, pc<=npc, go S_REQ; else hold.
//  - stall_cnt: +1 each cycle imem_req&~imem_ready; saturates at all-ones (no wrap).
//  - pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
// STRUCTURE
//  - Shared package mips_pkg: state encoding S_REQ/S_HOLD; PCSRC_SEQ/BR/JR/J select constants; RESET_PC default.
//  - One sub-module: pc_next_mux (combinational taken logic, priority select, low-bit clear). FSM, skid buffer, counter in top.
// TESTING
//  - Reset, ready=1 always, wpcir=1: imem_addr 0,4,8 on consecutive cycles; if_pc4 4,8,12; if_valid rises 1 cycle after first req.
//  - beq in ID, rsrtequ=1, bpc=32'h40: delay-slot word enters IF/ID, then imem_addr=32'h40; rsrtequ=0 -> sequential pc+4.
//  - bne, rsrtequ=0 -> bpc; id_jr&id_j both set, ra=32'h100, jpc=32'h200 -> 32'h100; ra=32'h103 -> 32'h100.
//  - ready high but wpcir low 3 cycles: IF/ID and pc frozen, imem_req drops after capture; wpcir=1 -> buffered word loads, req resumes at npc.
//  - ready low 5 cycles, wpcir=1: 5 bubbles (if_valid=0), stall_cnt+=5, imem_addr stable throughout.
//  - rst asserted mid-wait at pc=32'h20: next cycle pc=RESET_PC, if_valid=0, stall_cnt=0; pc=32'hFFFF_FFFC sequential -> 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch front end.
// Holds the fetch FSM encoding and next-PC source selects.
package mips_pkg;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_t;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'd0,
        PCSRC_BR  = 2'd1,
        PCSRC_JR  = 2'd2,
        PCSRC_J   = 2'd3
    } pcsrc_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory fetch port: request/address out, ready/data back.
// The fetch unit is the master; instruction memory is the slave.
interface fetch_pc_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/pc_next_mux.sv
// Next-PC selection for branches/jumps resolved in ID.
// Priority jr > j > taken branch > sequential; result is word aligned.
module pc_next_mux
    import mips_pkg::*;
(
    input  logic        id_valid,
    input  logic        id_beq,
    input  logic        id_bne,
    input  logic        id_j,
    input  logic        id_jr,
    input  logic        rsrtequ,
    input  logic [31:0] pc4,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] ra,
    output logic [31:0] npc
);

    logic        taken;
    pcsrc_t      pcsrc;
    logic [31:0] target;

    // A bubble in ID must never redirect the fetch stream.
    always_comb begin
        taken = id_valid & ((id_beq & rsrtequ) | (id_bne & ~rsrtequ));
        pcsrc = PCSRC_SEQ;
        if (id_valid & id_jr) begin
            pcsrc = PCSRC_JR;
        end else if (id_valid & id_j) begin
            pcsrc = PCSRC_J;
        end else if (taken) begin
            pcsrc = PCSRC_BR;
        end
    end

    always_comb begin
        target = pc4;
        unique case (pcsrc)
            PCSRC_SEQ: target = pc4;
            PCSRC_BR:  target = bpc;
            PCSRC_JR:  target = ra;
            PCSRC_J:   target = jpc;
        endcase
        npc = word_align(target);
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register, fetch handshake FSM, IF/ID register and stall skid buffer.
// A word fetched while ID stalls is parked in the buffer until wpcir.
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wpcir,
    input  logic             id_beq,
    input  logic             id_bne,
    input  logic             id_j,
    input  logic             id_jr,
    input  logic             rsrtequ,
    input  logic [31:0]      bpc,
    input  logic [31:0]      jpc,
    input  logic [31:0]      ra,
    fetch_pc_unit_if.master  imem,
    output logic [31:0]      if_inst,
    output logic [31:0]      if_pc4,
    output logic             if_valid,
    output logic [31:0]      pc,
    output logic [CNT_W-1:0] stall_cnt
);

    fetch_state_t state;
    fetch_state_t state_nx;

    logic [31:0] buf_q;
    logic [31:0] pc4;
    logic [31:0] npc;
    logic        fire;
    logic        capture;
    logic        drain;
    logic        bubble;
    logic        wait_cyc;

    assign pc4            = pc + 32'd4;
    assign imem.imem_addr = pc;

    pc_next_mux u_pc_next_mux (
        .id_valid (if_valid),
        .id_beq   (id_beq),
        .id_bne   (id_bne),
        .id_j     (id_j),
        .id_jr    (id_jr),
        .rsrtequ  (rsrtequ),
        .pc4      (pc4),
        .bpc      (bpc),
        .jpc      (jpc),
        .ra       (ra),
        .npc      (npc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_REQ: begin
                if (imem.imem_ready & ~wpcir) begin
                    state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                if (wpcir) begin
                    state_nx = S_REQ;
                end
            end
        endcase
    end

    // Request is suppressed during reset so an abandoned fetch is dropped.
    always_comb begin
        imem.imem_req = 1'b0;
        fire          = 1'b0;
        capture       = 1'b0;
        drain         = 1'b0;
        bubble        = 1'b0;
        unique case (state)
            S_REQ: begin
                imem.imem_req = ~rst;
                fire          = imem.imem_ready & wpcir;
                capture       = imem.imem_ready & ~wpcir;
                bubble        = ~imem.imem_ready & wpcir;
            end
            S_HOLD: begin
                drain = wpcir;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            if_inst  <= '0;
            if_pc4   <= '0;
            if_valid <= 1'b0;
        end else begin
            unique case (1'b1)
                fire: begin
                    if_inst  <= imem.imem_rdata;
                    if_pc4   <= pc4;
                    if_valid <= 1'b1;
                    pc       <= npc;
                end
                drain: begin
                    if_inst  <= buf_q;
                    if_pc4   <= pc4;
                    if_valid <= 1'b1;
                    pc       <= npc;
                end
                bubble: begin
                    if_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= '0;
        end else if (capture) begin
            buf_q <= imem.imem_rdata;
        end
    end

    assign wait_cyc = imem.imem_req & ~imem.imem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (wait_cyc & ~(&stall_cnt)) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a cycle-level reference model.
// Instruction memory is a fixed address-to-word function.
module tb_fetch_pc_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wpcir = 1'b1;
    logic        id_beq = 1'b0;
    logic        id_bne = 1'b0;
    logic        id_j = 1'b0;
    logic        id_jr = 1'b0;
    logic        rsrtequ = 1'b0;
    logic [31:0] bpc = '0;
    logic [31:0] jpc = '0;
    logic [31:0] ra = '0;
    logic        ready = 1'b1;

    logic [31:0] if_inst;
    logic [31:0] if_pc4;
    logic        if_valid;
    logic [31:0] pc;
    logic [31:0] stall_cnt;

    int n_tests = 0;
    int n_fail = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC000_0000 | {2'b00, a[31:2]};
    endfunction

    fetch_pc_unit_if bus ();

    assign bus.imem_ready = ready;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    always #5 clk = ~clk;

    fetch_pc_unit #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wpcir     (wpcir),
        .id_beq    (id_beq),
        .id_bne    (id_bne),
        .id_j      (id_j),
        .id_jr     (id_jr),
        .rsrtequ   (rsrtequ),
        .bpc       (bpc),
        .jpc       (jpc),
        .ra        (ra),
        .imem      (bus.master),
        .if_inst   (if_inst),
        .if_pc4    (if_pc4),
        .if_valid  (if_valid),
        .pc        (pc),
        .stall_cnt (stall_cnt)
    );

    task automatic cmp(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want,
                     $time);
        end
    endtask

    // Reference model: fetch address, IF/ID contents, a parked word flag.
    logic [31:0] m_pc = '0;
    logic [31:0] m_inst = '0;
    logic [31:0] m_pc4 = '0;
    logic        m_valid = 1'b0;
    logic        m_parked = 1'b0;
    logic [31:0] m_word = '0;
    logic [31:0] m_cnt = '0;
    bit          checking = 1'b0;

    function automatic logic [31:0] redirect();
        logic [31:0] t;
        t = m_pc + 32'd4;
        if (m_valid) begin
            if (id_jr) t = ra;
            else if (id_j) t = jpc;
            else if ((id_beq && rsrtequ) || (id_bne && !rsrtequ)) t = bpc;
        end
        return t & 32'hFFFF_FFFC;
    endfunction

    task automatic retire(input logic [31:0] w);
        logic [31:0] nxt;
        nxt     = redirect();
        m_inst  = w;
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = nxt;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_pc     = 32'h0;
            m_inst   = '0;
            m_pc4    = '0;
            m_valid  = 1'b0;
            m_parked = 1'b0;
            m_cnt    = '0;
            checking = 1'b1;
        end else if (m_parked) begin
            if (wpcir) begin
                retire(m_word);
                m_parked = 1'b0;
            end
        end else if (ready) begin
            if (wpcir) begin
                retire(mem_word(m_pc));
            end else begin
                m_word   = mem_word(m_pc);
                m_parked = 1'b1;
            end
        end else begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (wpcir) m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            cmp("m_req", {31'b0, bus.imem_req}, {31'b0, !rst && !m_parked});
            cmp("m_addr", bus.imem_addr, m_pc);
            cmp("m_pc", pc, m_pc);
            cmp("m_if_inst", if_inst, m_inst);
            cmp("m_if_pc4", if_pc4, m_pc4);
            cmp("m_if_valid", {31'b0, if_valid}, {31'b0, m_valid});
            cmp("m_stall_cnt", stall_cnt, m_cnt);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tick(2);
        cmp("rst_req", {31'b0, bus.imem_req}, 32'd0);
        cmp("rst_pc", pc, 32'h0);
        cmp("rst_valid", {31'b0, if_valid}, 32'd0);
        cmp("rst_cnt", stall_cnt, 32'd0);
        rst = 1'b0;
        #1;
        cmp("seq_addr0", bus.imem_addr, 32'h0);
        cmp("seq_req0", {31'b0, bus.imem_req}, 32'd1);
        tick(1);
        cmp("seq_addr1", bus.imem_addr, 32'h4);
        cmp("seq_pc4_1", if_pc4, 32'h4);
        cmp("seq_valid1", {31'b0, if_valid}, 32'd1);
        cmp("seq_inst1", if_inst, 32'hC000_0000);
        tick(1);
        cmp("seq_addr2", bus.imem_addr, 32'h8);
        cmp("seq_pc4_2", if_pc4, 32'h8);
        tick(1);
        cmp("seq_pc4_3", if_pc4, 32'hC);

        id_beq = 1'b1; rsrtequ = 1'b1; bpc = 32'h40;
        tick(1);
        cmp("beq_slot_pc4", if_pc4, 32'h10);
        cmp("beq_target", bus.imem_addr, 32'h40);
        id_beq = 1'b0;
        tick(1);
        cmp("beq_fetch", if_inst, 32'hC000_0010);
        id_beq = 1'b1; rsrtequ = 1'b0;
        tick(1);
        cmp("beq_nt", pc, 32'h48);
        id_beq = 1'b0; id_bne = 1'b1; bpc = 32'h80;
        tick(1);
        cmp("bne_t", pc, 32'h80);
        id_bne = 1'b0; id_jr = 1'b1; id_j = 1'b1;
        ra = 32'h100; jpc = 32'h200;
        tick(1);
        cmp("jr_over_j", pc, 32'h100);
        id_j = 1'b0; ra = 32'h103;
        tick(1);
        cmp("jr_align", pc, 32'h100);
        id_jr = 1'b0;

        wpcir = 1'b0;
        tick(1);
        cmp("hold_req", {31'b0, bus.imem_req}, 32'd0);
        tick(2);
        cmp("hold_pc", pc, 32'h100);
        cmp("hold_pc4", if_pc4, 32'h104);
        wpcir = 1'b1;
        tick(1);
        cmp("drain_inst", if_inst, 32'hC000_0040);
        cmp("drain_pc", bus.imem_addr, 32'h104);
        cmp("drain_req", {31'b0, bus.imem_req}, 32'd1);

        ready = 1'b0;
        tick(1);
        cmp("wait_bubble", {31'b0, if_valid}, 32'd0);
        tick(4);
        cmp("wait_addr", bus.imem_addr, 32'h104);
        cmp("wait_cnt", stall_cnt, 32'd5);
        ready = 1'b1;
        tick(1);
        cmp("wait_done", if_pc4, 32'h108);

        id_j = 1'b1; jpc = 32'h20;
        tick(1);
        id_j = 1'b0;
        cmp("j_20", pc, 32'h20);
        ready = 1'b0;
        tick(2);
        cmp("pre_rst_cnt", stall_cnt, 32'd7);
        rst = 1'b1;
        tick(1);
        cmp("mid_rst_pc", pc, 32'h0);
        cmp("mid_rst_valid", {31'b0, if_valid}, 32'd0);
        cmp("mid_rst_cnt", stall_cnt, 32'd0);
        cmp("mid_rst_req", {31'b0, bus.imem_req}, 32'd0);
        rst = 1'b0; ready = 1'b1;
        #1;
        cmp("post_rst_req", {31'b0, bus.imem_req}, 32'd1);
        tick(1);
        id_j = 1'b1; jpc = 32'hFFFF_FFFC;
        tick(1);
        id_j = 1'b0;
        cmp("wrap_pc", pc, 32'hFFFF_FFFC);
        tick(1);
        cmp("wrap_pc4", if_pc4, 32'h0);
        cmp("wrap_next", pc, 32'h0);

        ready = 1'b0; wpcir = 1'b0;
        tick(2);
        ready = 1'b1; wpcir = 1'b1;
        tick(3);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
